// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 8N1 UART receiver with 16x oversampling and a 2-of-3 majority vote.
// A 2-flop synchronizer feeds a tick divider that is re-phased on each start
// edge. The FSM walks START/DATA/STOP one sample tick at a time and produces a
// registered byte, a one-cycle valid strobe, a held status level and a
// framing-error flag.
module uart_rx_os16 #(
    parameter int unsigned CLK_DIV = 651
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_status,
    output logic       rx_busy,
    output logic       frame_err
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    logic        syncMeta_q;
    logic        rxSync_q;

    logic [15:0] divCnt_q,    divCnt_d;
    logic [2:0]  state_q,     state_d;
    logic [3:0]  sampleIdx_q, sampleIdx_d;
    logic [2:0]  bitCnt_q,    bitCnt_d;
    logic        vote7_q,     vote7_d;
    logic        vote8_q,     vote8_d;
    logic [7:0]  shift_q,     shift_d;
    logic [7:0]  rxData_q,    rxData_d;
    logic        rxValid_q,   rxValid_d;
    logic        rxStatus_q,  rxStatus_d;
    logic        frameErr_q,  frameErr_d;

    logic        tick;
    logic        vote;

    assign tick = (divCnt_q == DIV_LAST);

    // The third sample is taken live on the s=9 tick, so the vote uses rxSync_q directly.
    assign vote = (vote7_q & vote8_q) | (vote7_q & rxSync_q) | (vote8_q & rxSync_q);

    // Two-flop synchronizer for the asynchronous line; idles high out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            syncMeta_q <= 1'b1;
            rxSync_q   <= 1'b1;
        end else begin
            syncMeta_q <= uart_rx;
            rxSync_q   <= syncMeta_q;
        end
    end

    // Next-state logic: divider, sample/bit counters, voting and frame decisions.
    always_comb begin
        divCnt_d    = tick ? 16'd0 : divCnt_q + 16'd1;
        state_d     = state_q;
        sampleIdx_d = sampleIdx_q;
        bitCnt_d    = bitCnt_q;
        vote7_d     = vote7_q;
        vote8_d     = vote8_q;
        shift_d     = shift_q;
        rxData_d    = rxData_q;
        rxValid_d   = 1'b0;
        rxStatus_d  = rxStatus_q;
        frameErr_d  = frameErr_q;

        case (state_q)
            ST_IDLE: begin
                if (!rxSync_q) begin
                    state_d     = ST_START;
                    sampleIdx_d = 4'd0;
                    divCnt_d    = 16'd0;
                end
            end
            ST_START, ST_DATA, ST_STOP: begin
                if (tick) begin
                    sampleIdx_d = sampleIdx_q + 4'd1;
                    if (sampleIdx_q == 4'd7) begin
                        vote7_d = rxSync_q;
                    end
                    if (sampleIdx_q == 4'd8) begin
                        vote8_d = rxSync_q;
                    end
                    if (sampleIdx_q == 4'd9) begin
                        case (state_q)
                            ST_START: begin
                                if (vote) begin
                                    state_d = ST_IDLE;
                                end else begin
                                    rxStatus_d = 1'b0;
                                    frameErr_d = 1'b0;
                                end
                            end
                            ST_DATA: begin
                                shift_d = {vote, shift_q[7:1]};
                            end
                            default: begin
                                if (vote) begin
                                    rxData_d   = shift_q;
                                    rxValid_d  = 1'b1;
                                    rxStatus_d = 1'b1;
                                    state_d    = ST_IDLE;
                                end else begin
                                    frameErr_d = 1'b1;
                                    state_d    = ST_WAIT_HIGH;
                                end
                            end
                        endcase
                    end
                    if (sampleIdx_q == 4'd15) begin
                        if (state_q == ST_START) begin
                            state_d  = ST_DATA;
                            bitCnt_d = 3'd0;
                        end else if (state_q == ST_DATA) begin
                            if (bitCnt_q == 3'd7) begin
                                state_d = ST_STOP;
                            end else begin
                                bitCnt_d = bitCnt_q + 3'd1;
                            end
                        end
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (rxSync_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any frame in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divCnt_q    <= 16'd0;
            state_q     <= ST_IDLE;
            sampleIdx_q <= 4'd0;
            bitCnt_q    <= 3'd0;
            vote7_q     <= 1'b1;
            vote8_q     <= 1'b1;
            shift_q     <= 8'h00;
            rxData_q    <= 8'h00;
            rxValid_q   <= 1'b0;
            rxStatus_q  <= 1'b0;
            frameErr_q  <= 1'b0;
        end else begin
            divCnt_q    <= divCnt_d;
            state_q     <= state_d;
            sampleIdx_q <= sampleIdx_d;
            bitCnt_q    <= bitCnt_d;
            vote7_q     <= vote7_d;
            vote8_q     <= vote8_d;
            shift_q     <= shift_d;
            rxData_q    <= rxData_d;
            rxValid_q   <= rxValid_d;
            rxStatus_q  <= rxStatus_d;
            frameErr_q  <= frameErr_d;
        end
    end

    assign rx_data   = rxData_q;
    assign rx_valid  = rxValid_q;
    assign rx_status = rxStatus_q;
    assign frame_err = frameErr_q;
    assign rx_busy   = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);

endmodule

// File: tb/tb_uart_rx_os16.sv
// tb_uart_rx_os16: directed scenarios for uart_rx_os16 with CLK_DIV=4.
// Expected bytes are queued when a good frame is driven and popped whenever
// the receiver strobes rx_valid.
module tb_uart_rx_os16;

    localparam int D = 4;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       uart_rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_status;
    logic       rx_busy;
    logic       frame_err;

    int compared       = 0;
    int mismatched     = 0;
    int cycleCount     = 0;
    int validCount     = 0;
    int lastValidCycle = 0;
    logic [7:0] expQ[$];

    uart_rx_os16 #(.CLK_DIV(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_status (rx_status),
        .rx_busy   (rx_busy),
        .frame_err (frame_err)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Free-running edge counter used to measure latency.
    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame cycle by cycle; k counts clocks from the falling start edge.
    // glitchPos/glitchMask invert the line for the D cycles feeding selected sample ticks.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input int glitchPos,
                                 input logic [15:0] glitchMask, input int abortAt, input int checkAt);
        for (int k = 0; k < 160 * D; k++) begin
            int   p;
            int   m;
            logic v;
            if (k == abortAt) return;
            if (k == checkAt) begin
                checkOutput("busy_mid_frame", rx_busy, 1);
                checkOutput("ferr_cleared_at_start", frame_err, 0);
            end
            p = k / (16 * D);
            if (p == 0) v = 1'b0;
            else if (p <= 8) v = data[p-1];
            else v = stopBit;
            if (k > 0) begin
                m = (k - 1) / D;
                if ((m / 16) == glitchPos && glitchMask[m % 16]) v = ~v;
            end
            uart_rx = v;
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard monitor: every valid strobe must match the oldest queued byte.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            validCount++;
            lastValidCycle = cycleCount;
            checkOutput("valid_expected", 32'(expQ.size() > 0), 1);
            if (expQ.size() > 0) begin
                checkOutput("rx_data_at_valid", rx_data, expQ.pop_front());
            end
            checkOutput("status_at_valid", rx_status, 1);
            checkOutput("ferr_at_valid", frame_err, 0);
        end
    end

    initial begin
        int startCycle;
        int prevValid;
        int latency;

        // Reset values, during and after reset.
        waitCycles(5);
        checkOutput("reset_rx_data", rx_data, 8'h00);
        checkOutput("reset_rx_valid", rx_valid, 0);
        checkOutput("reset_rx_status", rx_status, 0);
        checkOutput("reset_rx_busy", rx_busy, 0);
        checkOutput("reset_frame_err", frame_err, 0);
        reset = 1'b0;
        waitCycles(20);
        checkOutput("idle_busy", rx_busy, 0);
        checkOutput("idle_rx_data", rx_data, 8'h00);

        // Ideal 0xA5 and its latency from the pin edge.
        expQ.push_back(8'hA5);
        startCycle = cycleCount;
        applyStimulus(8'hA5, 1'b1, -1, 16'h0000, -1, -1);
        waitCycles(10);
        latency = lastValidCycle - startCycle;
        checkOutput("latency_619pm1", 32'(latency >= 618 && latency <= 620), 1);
        checkOutput("a5_valid_count", validCount, 1);
        checkOutput("a5_rx_data", rx_data, 8'hA5);
        checkOutput("a5_status", rx_status, 1);
        checkOutput("a5_frame_err", frame_err, 0);

        // Glitch of 16 cycles is rejected as a false start.
        prevValid = validCount;
        uart_rx = 1'b0;
        waitCycles(16);
        checkOutput("glitch_busy_during", rx_busy, 1);
        uart_rx = 1'b1;
        waitCycles(60);
        checkOutput("glitch_busy_after", rx_busy, 0);
        checkOutput("glitch_rx_data", rx_data, 8'hA5);
        checkOutput("glitch_no_valid", validCount, prevValid);
        checkOutput("glitch_status_kept", rx_status, 1);

        // Framing error with the line held low for two more bit times.
        prevValid = validCount;
        applyStimulus(8'h3C, 1'b0, -1, 16'h0000, -1, -1);
        waitCycles(32 * D);
        checkOutput("ferr_set", frame_err, 1);
        checkOutput("ferr_no_restart", rx_busy, 0);
        checkOutput("ferr_rx_data_kept", rx_data, 8'hA5);
        checkOutput("ferr_no_valid", validCount, prevValid);
        checkOutput("ferr_status_cleared", rx_status, 0);
        uart_rx = 1'b1;
        waitCycles(20);
        checkOutput("ferr_held_idle", frame_err, 1);
        expQ.push_back(8'h81);
        applyStimulus(8'h81, 1'b1, -1, 16'h0000, -1, 12 * D);
        waitCycles(10);
        checkOutput("x81_rx_data", rx_data, 8'h81);
        checkOutput("x81_frame_err", frame_err, 0);

        // Back-to-back frames with no idle gap.
        prevValid = validCount;
        expQ.push_back(8'h00);
        expQ.push_back(8'hFF);
        applyStimulus(8'h00, 1'b1, -1, 16'h0000, -1, -1);
        applyStimulus(8'hFF, 1'b1, -1, 16'h0000, -1, -1);
        waitCycles(10);
        checkOutput("b2b_valid_count", validCount, prevValid + 2);
        checkOutput("b2b_rx_data", rx_data, 8'hFF);

        // Majority vote: single glitch masked, double glitch flips bit 2.
        expQ.push_back(8'h55);
        applyStimulus(8'h55, 1'b1, 3, 16'h0100, -1, -1);
        waitCycles(10);
        checkOutput("maj_single_rx_data", rx_data, 8'h55);
        expQ.push_back(8'h51);
        applyStimulus(8'h55, 1'b1, 3, 16'h0180, -1, -1);
        waitCycles(10);
        checkOutput("maj_double_rx_data", rx_data, 8'h51);

        // Reset during data bit 3 of 0xC3.
        prevValid = validCount;
        applyStimulus(8'hC3, 1'b1, -1, 16'h0000, 72 * D, -1);
        reset = 1'b1;
        uart_rx = 1'b1;
        #1;
        checkOutput("midrst_rx_data", rx_data, 8'h00);
        checkOutput("midrst_rx_valid", rx_valid, 0);
        checkOutput("midrst_rx_status", rx_status, 0);
        checkOutput("midrst_rx_busy", rx_busy, 0);
        checkOutput("midrst_frame_err", frame_err, 0);
        waitCycles(8);
        checkOutput("midrst_busy_held", rx_busy, 0);
        reset = 1'b0;
        waitCycles(200);
        checkOutput("midrst_no_valid", validCount, prevValid);
        checkOutput("midrst_busy_after", rx_busy, 0);
        expQ.push_back(8'h5A);
        applyStimulus(8'h5A, 1'b1, -1, 16'h0000, -1, -1);
        waitCycles(10);
        checkOutput("x5a_rx_data", rx_data, 8'h5A);
        checkOutput("x5a_status", rx_status, 1);

        // All queued bytes delivered, and nothing extra.
        checkOutput("queue_drained", expQ.size(), 0);
        checkOutput("total_valid_count", validCount, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
